// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding bus request at a time, and a small FIFO
// of {pc, instr} pairs that feeds decode through a valid/ready handshake.
module fetch_unit #(
  parameter logic [63:0] PC_RESET = 64'h8000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [31:0] out_raw_instr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_e;

  state_e                   state_q, state_d;
  logic [63:0]              fetch_pc_q, fetch_pc_d;
  logic [63:0]              pend_pc_q, pend_pc_d;
  logic [63:0]              req_addr_q, req_addr_d;
  logic [DEPTH-1:0][63:0]   pc_mem_q, pc_mem_d;
  logic [DEPTH-1:0][31:0]   instr_mem_q, instr_mem_d;
  logic [PTR_W-1:0]         head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]         count_q, count_d;

  logic        enq, deq;
  logic [63:0] redir_pc;

  assign redir_pc = {redirect_pc[63:2], 2'b00};

  // Request FSM. A redirect never issues in the same cycle, which keeps the
  // new PC one cycle away from the bus.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    pend_pc_d  = pend_pc_q;
    req_addr_d = req_addr_q;
    enq        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (redirect_valid) begin
          fetch_pc_d = redir_pc;
        end else if (count_q < DEPTH_C) begin
          state_d    = S_WAIT;
          req_addr_d = fetch_pc_q;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          if (iresp_data_ok) begin
            fetch_pc_d = redir_pc;
            state_d    = S_IDLE;
          end else begin
            pend_pc_d = redir_pc;
            state_d   = S_DROP;
          end
        end else if (iresp_data_ok) begin
          enq        = 1'b1;
          fetch_pc_d = req_addr_q + 64'd4;
          state_d    = S_IDLE;
        end
      end
      S_DROP: begin
        if (redirect_valid) begin
          pend_pc_d = redir_pc;
          if (iresp_data_ok) begin
            fetch_pc_d = redir_pc;
            state_d    = S_IDLE;
          end
        end else if (iresp_data_ok) begin
          fetch_pc_d = pend_pc_q;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO. Issue is gated on count < DEPTH, so enq never sees a full FIFO.
  always_comb begin
    pc_mem_d    = pc_mem_q;
    instr_mem_d = instr_mem_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    deq         = (count_q != '0) && out_ready && !redirect_valid;
    if (redirect_valid) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq) begin
        pc_mem_d[tail_q]    = req_addr_q;
        instr_mem_d[tail_q] = iresp_data;
        tail_d              = tail_q + PTR_W'(1);
      end
      if (deq) head_d = head_q + PTR_W'(1);
      count_d = count_q + CNT_W'(enq) - CNT_W'(deq);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      fetch_pc_q  <= PC_RESET;
      pend_pc_q   <= '0;
      req_addr_q  <= PC_RESET;
      pc_mem_q    <= '0;
      instr_mem_q <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      pend_pc_q   <= pend_pc_d;
      req_addr_q  <= req_addr_d;
      pc_mem_q    <= pc_mem_d;
      instr_mem_q <= instr_mem_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
    end
  end

  assign ireq_valid    = (state_q != S_IDLE);
  assign ireq_addr     = req_addr_q;
  assign out_valid     = (count_q != '0);
  assign out_pc        = pc_mem_q[head_q];
  assign out_raw_instr = instr_mem_q[head_q];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: fetch order, backpressure, redirects in each
// FSM state, and reset during an outstanding request.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_raw_instr;

  int checks = 0;
  int errors = 0;

  fetch_unit #(.PC_RESET(64'h8000_0000), .DEPTH(2)) dut (
    .clk           (clk),
    .reset         (reset),
    .ireq_valid    (ireq_valid),
    .ireq_addr     (ireq_addr),
    .iresp_data_ok (iresp_data_ok),
    .iresp_data    (iresp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_raw_instr (out_raw_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (ireq_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    assert (ireq_valid === 1'b1) else begin
      errors++;
      $error("FAIL %s_req_timeout observed %b expected 1", tag, ireq_valid);
    end
  endtask

  task automatic respond(input logic [31:0] d);
    iresp_data_ok = 1'b1;
    iresp_data    = d;
    tick();
    iresp_data_ok = 1'b0;
    iresp_data    = '0;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    iresp_data_ok  = 1'b0;
    redirect_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    iresp_data_ok  = 1'b0;
    iresp_data     = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b0;
    tick();
    tick();
    chk("rst_ireq_valid", ireq_valid, 0);
    chk("rst_ireq_addr", ireq_addr, 64'h8000_0000);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_raw", out_raw_instr, 0);

    // sequential fetch, decode always ready
    reset = 1'b0;
    out_ready = 1'b1;
    wait_req("seq0");
    chk("seq0_addr", ireq_addr, 64'h8000_0000);
    respond(32'h0000_0013);
    chk("seq0_out_valid", out_valid, 1);
    chk("seq0_out_pc", out_pc, 64'h8000_0000);
    chk("seq0_out_raw", out_raw_instr, 32'h0000_0013);
    chk("seq0_ireq_idle", ireq_valid, 0);
    wait_req("seq1");
    chk("seq1_addr", ireq_addr, 64'h8000_0004);
    chk("seq1_drained", out_valid, 0);
    respond(32'h0010_0093);
    chk("seq1_out_pc", out_pc, 64'h8000_0004);
    chk("seq1_out_raw", out_raw_instr, 32'h0010_0093);
    wait_req("seq2");
    chk("seq2_addr", ireq_addr, 64'h8000_0008);
    respond(32'h0020_0113);
    chk("seq2_out_pc", out_pc, 64'h8000_0008);
    chk("seq2_out_raw", out_raw_instr, 32'h0020_0113);

    // backpressure: FIFO fills at 2 entries and fetch stalls
    out_ready = 1'b0;
    do_reset();
    wait_req("bp0");
    chk("bp0_addr", ireq_addr, 64'h8000_0000);
    respond(32'hAAAA_0001);
    wait_req("bp1");
    chk("bp1_addr", ireq_addr, 64'h8000_0004);
    respond(32'hAAAA_0002);
    chk("bp_full_valid", out_valid, 1);
    chk("bp_full_pc", out_pc, 64'h8000_0000);
    chk("bp_full_raw", out_raw_instr, 32'hAAAA_0001);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_stall_ireq", ireq_valid, 0);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_deq1_pc", out_pc, 64'h8000_0004);
    chk("bp_deq1_raw", out_raw_instr, 32'hAAAA_0002);
    chk("bp_deq1_ireq", ireq_valid, 0);
    tick();
    chk("bp_deq2_valid", out_valid, 0);
    chk("bp_resume_valid", ireq_valid, 1);
    chk("bp_resume_addr", ireq_addr, 64'h8000_0008);

    // redirect while waiting: response for 0x...04 discarded
    do_reset();
    wait_req("rw0");
    respond(32'hCCCC_0001);
    wait_req("rw1");
    chk("rw1_addr", ireq_addr, 64'h8000_0004);
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_1002;
    tick();
    redirect_valid = 1'b0;
    chk("rw_flush_valid", out_valid, 0);
    chk("rw_drop_ireq", ireq_valid, 1);
    chk("rw_drop_addr_held", ireq_addr, 64'h8000_0004);
    tick();
    chk("rw_wait_out_valid", out_valid, 0);
    respond(32'hDEAD_BEEF);
    chk("rw_discard_valid", out_valid, 0);
    chk("rw_idle", ireq_valid, 0);
    tick();
    chk("rw_next_valid", ireq_valid, 1);
    chk("rw_next_addr", ireq_addr, 64'h8000_1000);

    // redirect coinciding with the response
    iresp_data_ok  = 1'b1;
    iresp_data     = 32'hBAD0_0001;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_2000;
    tick();
    iresp_data_ok  = 1'b0;
    redirect_valid = 1'b0;
    chk("rs_no_enq", out_valid, 0);
    chk("rs_idle", ireq_valid, 0);
    tick();
    chk("rs_next_valid", ireq_valid, 1);
    chk("rs_next_addr", ireq_addr, 64'h8000_2000);
    respond(32'h1234_5678);
    chk("rs_enq_pc", out_pc, 64'h8000_2000);
    chk("rs_enq_raw", out_raw_instr, 32'h1234_5678);

    // two redirects while dropping: last one wins
    wait_req("dd");
    chk("dd_addr", ireq_addr, 64'h8000_2004);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h100;
    tick();
    redirect_pc    = 64'h200;
    tick();
    redirect_valid = 1'b0;
    chk("dd_held_valid", ireq_valid, 1);
    chk("dd_held_addr", ireq_addr, 64'h8000_2004);
    tick();
    respond(32'hBAD0_0002);
    chk("dd_discard", out_valid, 0);
    chk("dd_idle", ireq_valid, 0);
    tick();
    chk("dd_next_valid", ireq_valid, 1);
    chk("dd_next_addr", ireq_addr, 64'h200);

    // reset mid-request; stale response lands while IDLE
    reset = 1'b1;
    tick();
    chk("rr_ireq_cleared", ireq_valid, 0);
    reset         = 1'b0;
    iresp_data_ok = 1'b1;
    iresp_data    = 32'hBAD0_0003;
    tick();
    iresp_data_ok = 1'b0;
    iresp_data    = '0;
    chk("rr_stale_ignored", out_valid, 0);
    chk("rr_req_valid", ireq_valid, 1);
    chk("rr_req_addr", ireq_addr, 64'h8000_0000);
    tick();
    chk("rr_still_empty", out_valid, 0);
    respond(32'h0000_0073);
    chk("rr_enq_valid", out_valid, 1);
    chk("rr_enq_pc", out_pc, 64'h8000_0000);
    chk("rr_enq_raw", out_raw_instr, 32'h0000_0073);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage directly upstream of the decoder. It keeps the fetch PC, runs one instruction-bus transaction at a time, and buffers returned instructions in a small FIFO. It presents each `{pc, raw_instr}` to decode through a valid/ready handshake. A redirect from a later stage flushes the FIFO and restarts fetch at the new PC. A response already in flight when the redirect arrives is dropped, not delivered.

## Interface
Parameters:
- `PC_RESET`, 64'h8000_0000, first fetch address after reset.
- `DEPTH`, 2, FIFO entries (power of two, ≥2).

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `ireq_valid` out 1: instruction-bus request valid.
- `ireq_addr` out 64: request address, 4-byte aligned.
- `iresp_data_ok` in 1: response valid this cycle; completes the request.
- `iresp_data` in 32: instruction word, sampled only when `iresp_data_ok` is high.
- `redirect_valid` in 1: flush and restart fetch.
- `redirect_pc` in 64: new fetch PC; bits [1:0] are ignored and treated as 0.
- `out_valid` out 1: FIFO head valid toward decode.
- `out_ready` in 1: decode accepts the head.
- `out_pc` out 64: PC of the head entry.
- `out_raw_instr` out 32: instruction word of the head entry; feeds the decoder's `raw_instr`.

## Operation
- State: `fetch_pc` (64 bits), FIFO (head pointer, tail pointer, `count`), `pend_pc` (64 bits), FSM.
- FSM states:
  - IDLE: no request outstanding.
  - WAIT: request outstanding; its response will be kept.
  - DROP: request outstanding; its response will be discarded.
- `ireq_valid` is 1 exactly when the FSM is in WAIT or DROP.
- `ireq_addr` is held stable from the first cycle `ireq_valid` is high until the cycle `iresp_data_ok` arrives.
- IDLE → WAIT: when `count < DEPTH` and there is no redirect. `ireq_addr` takes `fetch_pc`.
  - Issuing only when `count < DEPTH` reserves a FIFO slot, so an enqueue never meets a full FIFO.
- In WAIT, when `iresp_data_ok` is high without a redirect:
  - enqueue `{ireq_addr, iresp_data}`;
  - `fetch_pc` becomes `ireq_addr + 4`;
  - go to IDLE.
- Redirect priority is highest; it applies in every state:
  - clear the FIFO (`count` becomes 0, pointers reset);
  - drop any enqueue or dequeue in the same cycle.
- Redirect, by state:
  - In IDLE: `fetch_pc` becomes `redirect_pc`.
  - In WAIT without `iresp_data_ok`: go to DROP; `pend_pc` becomes `redirect_pc`.
  - In WAIT with `iresp_data_ok` in the same cycle: discard the data; `fetch_pc` becomes `redirect_pc`; go to IDLE.
  - In DROP: `pend_pc` becomes `redirect_pc` (the last redirect wins). If `iresp_data_ok` is also high, `fetch_pc` becomes `redirect_pc` and go to IDLE.
- DROP with `iresp_data_ok` and no redirect: discard the data; `fetch_pc` becomes `pend_pc`; go to IDLE.
- Dequeue happens when `out_valid & out_ready & ~redirect_valid`.
- If the FIFO holds fewer than DEPTH entries, enqueue and dequeue can occur in the same cycle; `count` is then unchanged.
- Pointers wrap modulo DEPTH.
- PC arithmetic is 64-bit unsigned and wraps silently at 2^64.

## Timing
- Reset values:
  - FSM in IDLE; `fetch_pc` = `PC_RESET`; `pend_pc` = 0; `count` = 0.
  - `ireq_valid` = 0; `ireq_addr` = `PC_RESET`.
  - `out_valid` = 0; `out_pc` = 0; `out_raw_instr` = 0. All FIFO storage is cleared.
- Reset wins over every other input in the same cycle.
- Reset in the middle of a request drops that request. Its later `iresp_data_ok` arrives while the FSM is in IDLE and is ignored.
- `iresp_data_ok` is ignored whenever the FSM is in IDLE.
- All outputs come from registers; there is no combinational path from any input to any output.
- Latency:
  - IDLE decision in cycle N gives `ireq_valid` high in N+1.
  - `iresp_data_ok` in cycle M gives `out_valid` high in M+1.
  - The earliest next request after that `iresp_data_ok` goes out in M+2.
- Redirect in cycle R:
  - `out_valid` = 0 in R+1.
  - From IDLE, the request to `redirect_pc` is issued in R+2 at the earliest.
- A handshake in the redirect cycle R does not count as a transfer; the consumer squashes it.
- When the FIFO is full, no request is issued; `ireq_valid` stays 0 until a dequeue.

## Test plan
- Reset; `iresp_data_ok` returned 1 cycle after each request; `out_ready`=1.
  - Expect addresses 0x8000_0000, 0x8000_0004, 0x8000_0008 in order.
  - Expect each `out_raw_instr` to equal the data returned for that address.
- `out_ready`=0 with DEPTH=2:
  - Expect exactly 2 entries to fill, then `ireq_valid` stays 0.
  - Raise `out_ready`: expect one dequeue per cycle and fetch to resume at 0x8000_0008.
- Redirect to 0x8000_1002 while in WAIT (request 0x8000_0004, response delayed 3 cycles):
  - Expect the response for 0x8000_0004 to be discarded.
  - Expect the next request address to be 0x8000_1000.
  - Expect `out_valid`=0 until that response returns.
- Redirect in the same cycle as `iresp_data_ok`:
  - Expect no enqueue, the FSM in IDLE, and the next request at the redirect PC.
- Two redirects while in DROP (0x100, then 0x200):
  - Expect the next request at 0x200.
- Reset asserted while `ireq_valid`=1, with the stale `iresp_data_ok` arriving 1 cycle after reset deasserts:
  - Expect nothing enqueued.
  - Expect the first request at `PC_RESET`.
